// File: rtl/frost32_decode_stage_if.sv
// rtl/frost32_decode_stage_if.sv - fetch-side and execute-side handshake bundle for the Frost32 decode stage
interface frost32_decode_stage_if #(
    parameter int INSTR_WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0]             out_group;
    logic [3:0]             out_ra;
    logic [3:0]             out_rb;
    logic [3:0]             out_rc;
    logic [3:0]             out_opcode;
    logic [INSTR_WIDTH-1:0] out_imm;
    logic [2:0]             out_ldst_type;
    logic                   out_writes_ra;
    logic                   out_illegal;

    // Surrounding pipeline: drives fetch side and downstream ready
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_group, out_ra, out_rb, out_rc,
               out_opcode, out_imm, out_ldst_type, out_writes_ra, out_illegal
    );

    // Decode stage
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_group, out_ra, out_rb, out_rc,
               out_opcode, out_imm, out_ldst_type, out_writes_ra, out_illegal
    );
endinterface

// File: rtl/frost32_decode_stage.sv
// rtl/frost32_decode_stage.sv - registered Frost32 decode stage with counted stalls; optional FROST32_DECODE_ILLEGAL_TRAP_EN
module frost32_decode_stage #(
    parameter int INSTR_WIDTH       = 32,
    parameter int MUL_STALL_CYCLES  = 2,
    parameter int LDST_STALL_CYCLES = 1,
    parameter int STALL_CNT_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    frost32_decode_stage_if.slave  bus
);

`ifdef FROST32_DECODE_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {IDLE, STALL, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, STALL} state_t;
`endif

    localparam logic [STALL_CNT_WIDTH-1:0] MUL_CNT  = STALL_CNT_WIDTH'(MUL_STALL_CYCLES);
    localparam logic [STALL_CNT_WIDTH-1:0] LDST_CNT = STALL_CNT_WIDTH'(LDST_STALL_CYCLES);

    state_t                     state;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;

    // Field positions are defined on the low 32 bits; wider words are ignored above bit 31
    logic [31:0]            word;
    logic [3:0]             dec_group;
    logic [3:0]             dec_opcode;
    logic                   fill_nz;
    logic                   dec_illegal;
    logic [INSTR_WIDTH-1:0] dec_imm;
    logic [2:0]             dec_ldst_type;
    logic                   dec_writes_ra;
    logic                   dec_is_mul;
    logic                   dec_is_ldst;
    logic                   accept;

    assign word       = bus.in_instr[31:0];
    assign dec_group  = word[31:28];
    assign dec_opcode = (dec_group == 4'd1 || dec_group == 4'd2) ? word[19:16] : word[3:0];
    assign fill_nz    = |word[15:4];

    assign bus.in_ready = !rst && (state == IDLE) && (!bus.out_valid || bus.out_ready) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    // Combinational decode of the presented word
    always_comb begin
        dec_illegal = 1'b0;
        if (dec_group > 4'd5)
            dec_illegal = 1'b1;
        if (dec_group == 4'd0 && dec_opcode >= 4'd14)
            dec_illegal = 1'b1;
        if ((dec_group == 4'd2 || dec_group == 4'd3 || dec_group == 4'd4) && dec_opcode >= 4'd10)
            dec_illegal = 1'b1;
        if ((dec_group == 4'd0 || dec_group == 4'd3 || dec_group == 4'd4) && fill_nz)
            dec_illegal = 1'b1;
        if (dec_group == 4'd5 && !dec_opcode[3] && fill_nz)
            dec_illegal = 1'b1;

        dec_imm = '0;
        if (!dec_illegal) begin
            case (dec_group)
                4'd1: begin
                    if (dec_opcode == 4'd3 || dec_opcode == 4'd5 || dec_opcode == 4'd14)
                        dec_imm = INSTR_WIDTH'($signed(word[15:0]));
                    else if (dec_opcode == 4'd15)
                        dec_imm = INSTR_WIDTH'({word[15:0], 16'h0000});
                    else
                        dec_imm = INSTR_WIDTH'(word[15:0]);
                end
                4'd2: dec_imm = INSTR_WIDTH'($signed(word[15:0]));
                4'd5: if (dec_opcode[3]) dec_imm = INSTR_WIDTH'($signed(word[15:4]));
                default: dec_imm = '0;
            endcase
        end

        dec_ldst_type = (dec_group == 4'd5) ? dec_opcode[2:0] : 3'd0;
        dec_writes_ra = !dec_illegal &&
                        ((dec_group == 4'd0) || (dec_group == 4'd1) ||
                         (dec_group == 4'd5 && dec_opcode[2:0] <= 3'd4));
        dec_is_mul    = !dec_illegal && (dec_group == 4'd0 || dec_group == 4'd1) && (dec_opcode == 4'd6);
        dec_is_ldst   = !dec_illegal && (dec_group == 4'd5);
    end

`ifndef FROST32_DECODE_ILLEGAL_TRAP_EN
    assign bus.out_illegal = 1'b0;
`endif

    // Output bundle register, stall counter and stage state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            stall_cnt         <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_group     <= '0;
            bus.out_ra        <= '0;
            bus.out_rb        <= '0;
            bus.out_rc        <= '0;
            bus.out_opcode    <= '0;
            bus.out_imm       <= '0;
            bus.out_ldst_type <= '0;
            bus.out_writes_ra <= 1'b0;
`ifdef FROST32_DECODE_ILLEGAL_TRAP_EN
            bus.out_illegal   <= 1'b0;
`endif
        end else if (flush) begin
            state         <= IDLE;
            stall_cnt     <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            if (accept) begin
                bus.out_valid     <= 1'b1;
                bus.out_group     <= dec_group;
                bus.out_ra        <= word[27:24];
                bus.out_rb        <= word[23:20];
                bus.out_rc        <= word[19:16];
                bus.out_opcode    <= dec_opcode;
                bus.out_imm       <= dec_imm;
                bus.out_ldst_type <= dec_ldst_type;
                bus.out_writes_ra <= dec_writes_ra;
`ifdef FROST32_DECODE_ILLEGAL_TRAP_EN
                bus.out_illegal   <= dec_illegal;
            end else if (bus.out_valid && bus.out_ready && state != TRAP) begin
`else
            end else if (bus.out_valid && bus.out_ready) begin
`endif
                bus.out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef FROST32_DECODE_ILLEGAL_TRAP_EN
                        if (dec_illegal) begin
                            state <= TRAP;
                        end else
`endif
                        if (dec_is_mul && MUL_STALL_CYCLES > 0) begin
                            state     <= STALL;
                            stall_cnt <= MUL_CNT;
                        end else if (dec_is_ldst && LDST_STALL_CYCLES > 0) begin
                            state     <= STALL;
                            stall_cnt <= LDST_CNT;
                        end
                    end
                end
                STALL: begin
                    stall_cnt <= stall_cnt - 1'b1;
                    if (stall_cnt <= 1)
                        state <= IDLE;
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: doc/frost32_decode_stage.md
Name: frost32_decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage for the Frost32 core. Sits between fetch and register-read/execute.
- Decodes groups 0-5 into register indices, opcode, an extended immediate, a load/store type, control flags and an illegal flag.
- Inserts back-pressure for multi-cycle ops (multiply, loads/stores) with an internal stall counter, replacing the single causes_stall bit with a counted, parametrised stall.

Parameters:
INSTR_WIDTH, 32, instruction and immediate-output width; must be 32 or wider (field positions below are defined on a 32-bit word, upper bits zero)
MUL_STALL_CYCLES, 2, cycles in_ready stays low after a Mul/Muli is accepted (0 = none)
LDST_STALL_CYCLES, 1, cycles in_ready stays low after any group-5 op is accepted (0 = none)
STALL_CNT_WIDTH, 4, stall counter width; both stall parameters must be below 2**STALL_CNT_WIDTH

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  discard the held instruction and any pending stall
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  INSTR_WIDTH  raw instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream consumes
out_group  out  4  instr[31:28]
out_ra, out_rb, out_rc  out  4 each  instr[27:24], [23:20], [19:16]
out_opcode  out  4  groups 0,3,4,5: instr[3:0]; groups 1,2: instr[19:16]
out_imm  out  INSTR_WIDTH  extended immediate
out_ldst_type  out  3  out_opcode[2:0], valid for group 5 only, else 0
out_writes_ra  out  1  group 0/1 non-illegal, or group-5 load (opcode[2:0] <= 4)
out_illegal  out  1  decode fault

Behaviour:
- Reset (async, rst=1): out_valid=0, all out_* fields=0, stall counter=0, state IDLE. in_ready is 0 while rst is asserted.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready): the decoded bundle registers on that edge and out_valid=1 the next cycle. Latency is 1 cycle.
- Output held stable while out_valid && !out_ready.
- Consume without accept: out_valid falls to 0.
- Immediate extension:
  - Group 1 opcodes 3, 5, 14 (Sltsi, Sgtsi, Addsi): sign-extend instr[15:0].
  - Group 1 opcode 15 (Cpyhi): instr[15:0]<<16.
  - Other group-1 opcodes: zero-extend instr[15:0].
  - Group 2: sign-extend instr[15:0].
  - Group 5 opcodes 8-15: sign-extend instr[15:4].
  - Everything else: 0.
- Illegal when any of:
  - group > 5
  - group 0 with opcode 14 or 15
  - groups 2/3/4 with opcode >= 10
  - groups 0/3/4 with fill instr[15:4] != 0
  - group 5 opcodes 0-7 with instr[15:4] != 0
  Illegal bundles have out_writes_ra=0 and out_imm=0.
- State machine:
  - IDLE -> STALL on accept of Mul (group 0, opcode 6) or Muli (group 1, opcode 6) with MUL_STALL_CYCLES>0. Counter loads MUL_STALL_CYCLES.
  - IDLE -> STALL on accept of group 5 with LDST_STALL_CYCLES>0. Counter loads LDST_STALL_CYCLES.
  - STALL: counter decrements every cycle regardless of out_ready. At counter==1 the next state is IDLE.
  - TRAP: only when the optional feature is enabled.
- Flush:
  - Highest priority.
  - Clears out_valid and counter, and forces IDLE on the next edge.
  - in_ready is 0 during the flush cycle, so nothing is accepted.
- Back-to-back non-stalling instructions with out_ready=1 sustain one per cycle.
- Reset mid-STALL returns to IDLE immediately, asynchronously.

Optional Feature:
- Macro: FROST32_DECODE_ILLEGAL_TRAP_EN
- Defined:
  - Accepting an illegal instruction sets out_illegal=1 and the state goes to TRAP.
  - In TRAP, in_ready=0 and the bundle is held (out_valid stays 1 after consumption is ignored, i.e. out_valid remains asserted) until flush or rst.
  - flush returns to IDLE.
- Undefined:
  - No TRAP state; out_illegal is tied to 0.
  - Illegal instructions pass as NOPs (out_writes_ra=0, out_imm=0) with no stall.

Test Plan:
- Reset then in_instr=0x0123_0000 (Add r1,r2,r3), out_ready=1 -> next cycle out_valid=1, group=0, ra=1, rb=2, rc=3, opcode=0, writes_ra=1, imm=0.
- 0x1120_FFFF (Addi) -> imm=0x0000_FFFF. Then 0x1123_FFFF (Sltsi) -> imm=0xFFFF_FFFF. Then 0x112F_1234 (Cpyhi) -> imm=0x1234_0000. Three consecutive cycles, no bubbles.
- 0x0123_0006 (Mul), MUL_STALL_CYCLES=2 -> in_ready=0 for exactly 2 cycles after accept, then 1.
- 0x5123_800C (Ldsbi) -> imm=0xFFFF_F800, ldst_type=4, writes_ra=1, in_ready low 1 cycle. Hold out_ready=0 for 3 cycles -> bundle stable throughout.
- 0x6000_0000 with TRAP_EN -> out_illegal=1, in_ready stays 0 for 10 cycles, flush -> out_valid=0, in_ready=1 next cycle. Without TRAP_EN -> out_illegal=0, writes_ra=0, no stall.
- Assert rst during a Mul stall (counter=1) -> outputs zero immediately. Deassert -> in_ready=1 next cycle.
